// File: rtl/regional_max_pkg.sv
// Shared types and helpers for the regional-maximum engine: FSM states,
// default geometry and {row,col} address packing.
package eda_regional_max_pkg;

    typedef enum logic [1:0] {IDLE, INIT, SCAN, FINISH} state_e;

    localparam int DEF_M            = 8;
    localparam int DEF_N            = 8;
    localparam int DEF_PIXEL_WIDTH  = 8;
    localparam int DEF_WINDOW_WIDTH = 3;
    localparam int DEF_I_WIDTH      = 3;
    localparam int DEF_J_WIDTH      = 3;

    function automatic int unsigned addr_row(input int unsigned addr, input int unsigned jw);
        return addr >> jw;
    endfunction

    function automatic int unsigned addr_col(input int unsigned addr, input int unsigned jw);
        return addr & ((32'd1 << jw) - 32'd1);
    endfunction

    function automatic int unsigned pack_addr(input int unsigned row, input int unsigned col,
                                              input int unsigned jw);
        return (row << jw) | col;
    endfunction

endpackage

// File: rtl/regional_max_window.sv
// Flag-clear decision for one pixel: any in-image neighbour that is higher,
// or equal but already known not to be a maximum, disqualifies the centre.
module regional_max_window
    import eda_regional_max_pkg::*;
#(
    parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
    parameter int WINDOW_WIDTH = DEF_WINDOW_WIDTH,
    parameter int NB           = WINDOW_WIDTH * WINDOW_WIDTH - 1
) (
    input  logic [PIXEL_WIDTH-1:0]         centre_i,
    input  logic [NB-1:0][PIXEL_WIDTH-1:0] nbr_i,
    input  logic [NB-1:0]                  nbr_flag_i,
    input  logic [NB-1:0]                  nbr_vld_i,
    output logic                           clear_flag_o
);

    logic [NB-1:0] hit;

    for (genvar k = 0; k < NB; k++) begin : g_hit
        assign hit[k] = nbr_vld_i[k] &
                        ((nbr_i[k] > centre_i) | ((nbr_i[k] == centre_i) & ~nbr_flag_i[k]));
    end

    assign clear_flag_o = |hit;

endmodule

// File: rtl/regional_max.sv
// 8-connected regional-maximum bitmap: image/flag register arrays, a raster
// scanner that refines the flag map in place until a pass changes nothing.
module regional_max
    import eda_regional_max_pkg::*;
#(
    parameter int M            = DEF_M,
    parameter int N            = DEF_N,
    parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
    parameter int WINDOW_WIDTH = DEF_WINDOW_WIDTH,
    parameter int I_WIDTH      = DEF_I_WIDTH,
    parameter int J_WIDTH      = DEF_J_WIDTH,
    parameter int ADDR_WIDTH   = I_WIDTH + J_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic                   write_en,
    output logic                   done,
    output logic [M-1:0][N-1:0]    matrix_output
);

    localparam int NB = WINDOW_WIDTH * WINDOW_WIDTH - 1;
    localparam logic [I_WIDTH:0]   M_L      = (I_WIDTH+1)'(M);
    localparam logic [J_WIDTH:0]   N_L      = (J_WIDTH+1)'(N);
    localparam logic [I_WIDTH-1:0] ROW_LAST = I_WIDTH'(M - 1);
    localparam logic [J_WIDTH-1:0] COL_LAST = J_WIDTH'(N - 1);

    logic [PIXEL_WIDTH-1:0] img_q [M][N];
    logic [M-1:0][N-1:0]    flag_q, flag_d;
    logic [M-1:0][N-1:0]    mout_q, mout_d;
    state_e                 state_q, state_d;
    logic [I_WIDTH-1:0]     row_q, row_d;
    logic [J_WIDTH-1:0]     col_q, col_d;
    logic                   changed_q, changed_d;
    logic                   done_q, done_d;

    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;

    // Host writes: only while idle, out-of-image addresses are dropped.
    logic [I_WIDTH-1:0] wr_row;
    logic [J_WIDTH-1:0] wr_col;
    logic               wr_ok;

    assign wr_row = I_WIDTH'(addr_row(32'(wr_addr), J_WIDTH));
    assign wr_col = J_WIDTH'(addr_col(32'(wr_addr), J_WIDTH));
    assign wr_ok  = (state_q == IDLE) && write_en &&
                    ({1'b0, wr_row} < M_L) && ({1'b0, wr_col} < N_L);

    always_ff @(posedge clk) begin
        if (wr_ok) img_q[wr_row][wr_col] <= pixel_in;
    end

    // Neighbour coordinates; an off-image side reuses the centre index and is masked invalid.
    logic [I_WIDTH-1:0] nrow    [WINDOW_WIDTH];
    logic [J_WIDTH-1:0] ncol    [WINDOW_WIDTH];
    logic               nrow_ok [WINDOW_WIDTH];
    logic               ncol_ok [WINDOW_WIDTH];

    always_comb begin
        nrow[0]    = (row_q != '0) ? row_q - I_WIDTH'(1) : row_q;
        nrow_ok[0] = (row_q != '0);
        nrow[1]    = row_q;
        nrow_ok[1] = 1'b1;
        nrow[2]    = (row_q != ROW_LAST) ? row_q + I_WIDTH'(1) : row_q;
        nrow_ok[2] = (row_q != ROW_LAST);
        ncol[0]    = (col_q != '0) ? col_q - J_WIDTH'(1) : col_q;
        ncol_ok[0] = (col_q != '0);
        ncol[1]    = col_q;
        ncol_ok[1] = 1'b1;
        ncol[2]    = (col_q != COL_LAST) ? col_q + J_WIDTH'(1) : col_q;
        ncol_ok[2] = (col_q != COL_LAST);
    end

    logic [NB-1:0][PIXEL_WIDTH-1:0] nbr_pix;
    logic [NB-1:0]                  nbr_flag;
    logic [NB-1:0]                  nbr_vld;
    logic                           clear_flag;

    for (genvar g = 0; g < WINDOW_WIDTH * WINDOW_WIDTH; g++) begin : g_nb
        if (g != NB / 2) begin : g_sel
            localparam int K  = (g < NB / 2) ? g : g - 1;
            localparam int DR = g / WINDOW_WIDTH;
            localparam int DC = g % WINDOW_WIDTH;
            assign nbr_pix[K]  = img_q[nrow[DR]][ncol[DC]];
            assign nbr_flag[K] = flag_q[nrow[DR]][ncol[DC]];
            assign nbr_vld[K]  = nrow_ok[DR] & ncol_ok[DC];
        end
    end

    regional_max_window #(
        .PIXEL_WIDTH  (PIXEL_WIDTH),
        .WINDOW_WIDTH (WINDOW_WIDTH),
        .NB           (NB)
    ) u_window (
        .centre_i     (img_q[row_q][col_q]),
        .nbr_i        (nbr_pix),
        .nbr_flag_i   (nbr_flag),
        .nbr_vld_i    (nbr_vld),
        .clear_flag_o (clear_flag)
    );

    logic clr;
    logic pass_changed;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        changed_d    = changed_q;
        flag_d       = flag_q;
        mout_d       = mout_q;
        done_d       = 1'b0;
        clr          = flag_q[row_q][col_q] & clear_flag;
        pass_changed = changed_q | clr;
        case (state_q)
            IDLE: if (start) state_d = INIT;
            INIT: begin
                flag_d    = '1;
                row_d     = '0;
                col_d     = '0;
                changed_d = 1'b0;
                state_d   = SCAN;
            end
            SCAN: begin
                if (clr) flag_d[row_q][col_q] = 1'b0;
                changed_d = pass_changed;
                if (col_q != COL_LAST) begin
                    col_d = col_q + J_WIDTH'(1);
                end else begin
                    col_d = '0;
                    if (row_q != ROW_LAST) begin
                        row_d = row_q + I_WIDTH'(1);
                    end else begin
                        // End of pass: another pass only if something moved.
                        row_d     = '0;
                        changed_d = 1'b0;
                        if (!pass_changed) state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                mout_d  = flag_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            changed_q <= 1'b0;
            flag_q    <= '0;
            mout_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            changed_q <= changed_d;
            flag_q    <= flag_d;
            mout_q    <= mout_d;
            done_q    <= done_d;
        end
    end

    assign done          = done_q;
    assign matrix_output = mout_q;

endmodule

// File: tb/tb_regional_max.sv
// Directed bench for regional_max: an 8x8 instance plus a 6x8 instance that
// share all inputs, checked against hand-computed maps and latencies.
module tb_regional_max;
    import eda_regional_max_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [7:0]       pixel_in;
    logic [5:0]       rd_addr;
    logic             start;
    logic [5:0]       wr_addr;
    logic             write_en;
    logic             done0, done1;
    logic [7:0][7:0]  mout0;
    logic [5:0][7:0]  mout1;

    int nvec = 0;
    int nerr = 0;
    int timg [8][8];
    int lat0, lat1, pulses0;

    always #5 clk = ~clk;

    regional_max u_dut0 (
        .clk(clk), .reset_n(reset_n), .pixel_in(pixel_in), .rd_addr(rd_addr),
        .start(start), .wr_addr(wr_addr), .write_en(write_en),
        .done(done0), .matrix_output(mout0)
    );

    regional_max #(.M(6)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .pixel_in(pixel_in), .rd_addr(rd_addr),
        .start(start), .wr_addr(wr_addr), .write_en(write_en),
        .done(done1), .matrix_output(mout1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] bit_at(input int i, input int j);
        logic [63:0] one;
        one = 64'd1;
        return one << (i * 8 + j);
    endfunction

    task automatic wr_px(input int i, input int j, input int v);
        write_en = 1'b1;
        wr_addr  = 6'(pack_addr(i, j, 3));
        pixel_in = 8'(v);
        @(negedge clk);
        write_en = 1'b0;
    endtask

    task automatic load_img();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                wr_px(i, j, timg[i][j]);
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                timg[i][j] = v;
    endtask

    // Starts a run; lat counts edges after the start-sampling edge until done.
    // Optionally pulses start or a write of (0,0)=9 mid-run.
    task automatic run(input int inj_at, input bit inj_start, input bit inj_wr);
        int  c;
        bit  seen0, seen1;
        lat0 = -1; lat1 = -1; pulses0 = 0; seen0 = 0; seen1 = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (c < 3000 && !(seen0 && seen1)) begin
            start = 1'b0; write_en = 1'b0;
            if (c == inj_at) begin
                start = inj_start; write_en = inj_wr;
                wr_addr = 6'd0; pixel_in = 8'd9;
            end
            @(negedge clk);
            c++;
            if (done0) begin
                if (!seen0) lat0 = c;
                seen0 = 1; pulses0++;
            end
            if (done1 && !seen1) begin
                lat1 = c; seen1 = 1;
            end
        end
        start = 1'b0; write_en = 1'b0;
        @(negedge clk);
        if (done0) pulses0++;
    endtask

    initial begin
        logic [63:0] e;
        reset_n = 1'b0; start = 1'b0; write_en = 1'b0;
        wr_addr = '0; rd_addr = '0; pixel_in = '0;
        repeat (2) @(negedge clk);
        chk("reset_done", 64'(done0), 64'd0);
        chk("reset_map", mout0, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        fill(5); load_img(); run(-1, 0, 0);
        chk("const_map", mout0, {64{1'b1}});
        chk("const_lat", 64'(lat0), 64'd66);
        chk("const_pulse", 64'(pulses0), 64'd1);

        fill(0); timg[3][4] = 9; load_img(); run(-1, 0, 0);
        chk("peak_map", mout0, bit_at(3, 4));
        chk("peak_pulse", 64'(pulses0), 64'd1);

        fill(3);
        timg[1][1] = 7; timg[1][2] = 7; timg[2][1] = 7; timg[2][2] = 7;
        timg[6][6] = 7; timg[6][7] = 8;
        load_img(); run(-1, 0, 0);
        e = bit_at(1, 1) | bit_at(1, 2) | bit_at(2, 1) | bit_at(2, 2) | bit_at(6, 7);
        chk("block_map", mout0, e);

        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) timg[i][j] = i + j;
        load_img(); run(-1, 0, 0);
        chk("ramp_map", mout0, bit_at(7, 7));
        chk("ramp_lat", 64'(lat0), 64'd130);

        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) timg[i][j] = 14 - i - j;
        load_img(); run(-1, 0, 0);
        chk("mirror_map", mout0, bit_at(0, 0));
        chk("mirror_lat", 64'(lat0), 64'd130);

        fill(5); load_img();
        run(20, 0, 1);
        chk("busy_wr_map", mout0, {64{1'b1}});
        run(-1, 0, 0);
        chk("busy_wr_rerun", mout0, {64{1'b1}});
        run(30, 1, 0);
        chk("busy_start_lat", 64'(lat0), 64'd66);
        chk("busy_start_map", mout0, {64{1'b1}});

        fill(4); load_img(); wr_px(7, 0, 9); run(-1, 0, 0);
        chk("range_map8", mout0, bit_at(7, 0));
        chk("range_map6", 64'(mout1), 64'hFFFF_FFFF_FFFF);
        chk("range_lat6", 64'(lat1), 64'd50);

        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) timg[i][j] = i + j;
        load_img();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_done", 64'(done0), 64'd0);
        chk("midrst_map", mout0, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        run(-1, 0, 0);
        chk("midrst_rerun_map", mout0, bit_at(7, 7));
        chk("midrst_rerun_lat", 64'(lat0), 64'd130);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
